// File: rtl/factorial_engine.sv
// Multi-cycle n! mod 2^WIDTH engine: a down-counter sequenced through a
// shift-add multiplier, with a start/done handshake and sticky overflow.
//
// state | meaning
// IDLE  | ready=1, waiting for start
// MUL   | WIDTH-cycle shift-add of mcnd*mplr into prod
// DEC   | cnt <= cnt-1, choose next factor or finish
// DONE  | publish result/overflow, pulse done for one cycle
module factorial_engine #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int BW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DEC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   cnt;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mcnd;
  logic [WIDTH-1:0]   mplr;
  logic [2*WIDTH-1:0] prod;
  logic [BW-1:0]      bitc;
  logic               ovf;

  // Stand-in for the downstream subtractor, driven with (cnt, 1).
  logic [WIDTH-1:0]   cnt_m1;
  assign cnt_m1 = cnt - WIDTH'(1);

  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] prod_nxt;
  logic               last_bit;

  assign addend   = mplr[0] ? ({{WIDTH{1'b0}}, mcnd} << bitc) : '0;
  assign prod_nxt = prod + addend;
  assign last_bit = (bitc == BW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      mcnd     <= '0;
      mplr     <= '0;
      prod     <= '0;
      bitc     <= '0;
      ovf      <= 1'b0;
      ready    <= 1'b1;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && ready) begin
            cnt   <= n;
            acc   <= WIDTH'(1);
            ovf   <= 1'b0;
            ready <= 1'b0;
            if (n <= WIDTH'(1)) begin
              state <= DONE;
            end else begin
              mcnd  <= WIDTH'(1);
              mplr  <= n;
              prod  <= '0;
              bitc  <= '0;
              state <= MUL;
            end
          end
        end

        MUL: begin
          prod <= prod_nxt;
          mplr <= mplr >> 1;
          bitc <= bitc + BW'(1);
          if (last_bit) begin
            acc   <= prod_nxt[WIDTH-1:0];
            ovf   <= ovf | (|prod_nxt[2*WIDTH-1:WIDTH]);
            state <= DEC;
          end
        end

        DEC: begin
          cnt <= cnt_m1;
          // A zero accumulator stays zero, so stop multiplying early.
          if ((acc == '0) || (cnt_m1 == WIDTH'(1))) begin
            state    <= DONE;
            done     <= 1'b1;
            result   <= acc;
            overflow <= ovf;
          end else begin
            mcnd  <= acc;
            mplr  <= cnt_m1;
            prod  <= '0;
            bitc  <= '0;
            state <= MUL;
          end
        end

        DONE: begin
          // Trivial jobs (n<=1) arrive here with done low and publish one cycle later.
          if (done) begin
            done  <= 1'b0;
            ready <= 1'b1;
            state <= IDLE;
          end else begin
            done     <= 1'b1;
            result   <= acc;
            overflow <= ovf;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
